// File: rtl/wishbone_mem_slave_pkg.sv
// Shared types and bus widths for the Wishbone memory responder.
// Optional error response is selected with the WB_ERR_EN macro.
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        WBS_IDLE,
        WBS_WAIT,
        WBS_RESP
    } wbs_state_t;

endpackage

// File: rtl/wishbone_mem_slave_if.sv
// Wishbone B4 classic-cycle signal bundle between controller and memory.
// Signal names keep the responder's _i/_o perspective.
interface wishbone_mem_slave_if;
    import wb_pkg::*;

    logic [31:0]        wb_adr_i;
    logic [WB_DW-1:0]   wb_dat_i;
    logic [WB_SELW-1:0] wb_sel_i;
    logic               wb_we_i;
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic [WB_DW-1:0]   wb_dat_o;
    logic               wb_ack_o;
    logic               wb_err_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );

endinterface

// File: rtl/wishbone_mem_slave_byte_en_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// The read register only changes on a read access, so it holds between reads.
module byte_en_ram
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WB_SELW-1:0]    be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WB_DW-1:0]      wdata,
    output logic [WB_DW-1:0]      rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WB_DW-1:0] mem [DEPTH];
    logic [WB_DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WB_SELW; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wishbone_mem_slave.sv
// Wishbone classic responder over byte_en_ram with fixed wait states.
// Define WB_ERR_EN to answer out-of-window requests with err instead of ack.
module wishbone_mem_slave
    import wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    wishbone_mem_slave_if.slave bus
);

    localparam logic [3:0] WS_INIT =
        4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
`ifdef WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    wbs_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       zero_q, zero_d;

    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DW-1:0]      dat_q, dat_d;
    logic [WB_SELW-1:0]    sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  hit_q, hit_d;

    logic                  accept;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] bus_idx;
    logic                  bus_hit;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [WB_DW-1:0]      cur_dat;
    logic [WB_SELW-1:0]    cur_sel;
    logic                  cur_we;
    logic                  cur_hit;
    logic [WB_DW-1:0]      ram_rdata;
    logic                  unused_adr;

    assign accept  = bus.wb_cyc_i & bus.wb_stb_i;
    assign bus_idx = bus.wb_adr_i[ADDR_WIDTH+1:2];
    assign bus_hit = bus.wb_adr_i[31:ADDR_WIDTH+2]
                  == BASE_ADDR[31:ADDR_WIDTH+2];
    assign unused_adr = ^bus.wb_adr_i[1:0];

    // Without wait states the access fires on the accept edge itself,
    // so the RAM must see the live bus rather than the latched copy.
    always_comb begin
        if (state_q == WBS_WAIT) begin
            cur_idx = adr_q;
            cur_dat = dat_q;
            cur_sel = sel_q;
            cur_we  = we_q;
            cur_hit = hit_q;
        end else begin
            cur_idx = bus_idx;
            cur_dat = bus.wb_dat_i;
            cur_sel = bus.wb_sel_i;
            cur_we  = bus.wb_we_i;
            cur_hit = bus_hit;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        zero_d  = zero_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        hit_d   = hit_q;
        fire    = 1'b0;

        unique case (state_q)
            WBS_IDLE, WBS_RESP: begin
                state_d = WBS_IDLE;
                if (accept) begin
                    adr_d = bus_idx;
                    dat_d = bus.wb_dat_i;
                    sel_d = bus.wb_sel_i;
                    we_d  = bus.wb_we_i;
                    hit_d = bus_hit;
                    if (NO_WAIT) begin
                        state_d = WBS_RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WBS_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            WBS_WAIT: begin
                if (!bus.wb_cyc_i) begin
                    state_d = WBS_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = WBS_RESP;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = WBS_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (fire) begin
            ack_d = cur_hit | ~ERR_EN;
            err_d = ~cur_hit & ERR_EN;
            if (!cur_we) begin
                if (cur_hit) begin
                    zero_d = 1'b0;
                end else if (!ERR_EN) begin
                    zero_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WBS_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
        end
    end

    byte_en_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (fire & cur_hit),
        .we   (cur_we),
        .be   (cur_sel),
        .addr (cur_idx),
        .wdata(cur_dat),
        .rdata(ram_rdata)
    );

    // zero_q masks the RAM register after reset and after a dropped read.
    assign bus.wb_dat_o = zero_q ? '0 : ram_rdata;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;

endmodule
